// File: rtl/i2c_poll_sequencer.sv
`default_nettype none
// ============================================================================
// Module : i2c_poll_sequencer
// Desc   : Timer-driven I2C sensor poll sequencer feeding a FWFT sample FIFO.
// Option : SAMPLE_AVG_EN -> push a 4-sample moving average instead of the raw byte.
// Rev    : 1.0 - initial release
// ============================================================================
module i2c_poll_sequencer #(
  parameter logic [6:0]  DEV_ADDR    = 7'b1110001,
  parameter logic [7:0]  REG_ADDR    = 8'hFF,
  parameter logic [15:0] PERIOD      = 16'd5000,
  parameter logic [15:0] START_HOLD  = 16'd100,
  parameter logic [15:0] XFER_CYCLES = 16'd10000,
  parameter logic [15:0] STOP_HOLD   = 16'd100,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       err_clr,
  output logic       i2c_en,
  output logic       i2c_mode,
  output logic [6:0] i2c_address,
  output logic [7:0] i2c_register,
  output logic       i2c_start,
  output logic       i2c_stop,
  output logic       i2c_repeat_start,
  input  logic [7:0] i2c_out,
  input  logic       i2c_ack,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       full,
  output logic       nack_err,
  output logic [7:0] ovf_cnt
);

  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  // A hold of 0 behaves like a hold of 1.
  function automatic logic [15:0] load_val(input logic [15:0] n);
    return (n == 16'd0) ? 16'd0 : n - 16'd1;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic          en_q;
  logic          nack_q, nack_d;
  logic [7:0]    ovf_q, ovf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          timer_done, sample, push, pop, push_ok, is_full;
  logic [7:0]    push_data;

  assign timer_done = (timer_q == 16'd0);
  assign sample     = (state_q == S_XFER) && timer_done;
  assign push       = sample && i2c_ack;
  assign pop        = rd_en && (count_q != '0);
  assign is_full    = (count_q == C_DEPTH);
  assign push_ok    = push && (!is_full || pop);

  always_comb begin
    state_d = state_q;
    timer_d = timer_done ? timer_q : timer_q - 16'd1;
    case (state_q)
      S_IDLE: if (en) begin
        state_d = S_START;
        timer_d = load_val(START_HOLD);
      end
      S_START: if (timer_done) begin
        state_d = S_XFER;
        timer_d = load_val(XFER_CYCLES);
      end
      S_XFER: if (timer_done) begin
        state_d = S_STOP;
        timer_d = load_val(STOP_HOLD);
      end
      S_STOP: if (timer_done) begin
        state_d = en ? S_WAIT : S_IDLE;
        timer_d = en ? load_val(PERIOD) : 16'd0;
      end
      S_WAIT: begin
        if (!en) begin
          state_d = S_IDLE;
          timer_d = 16'd0;
        end else if (timer_done) begin
          state_d = S_START;
          timer_d = load_val(START_HOLD);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = 16'd0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    ovf_d    = (push && !push_ok && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
    // A nack in the same cycle as err_clr keeps the error set.
    nack_d   = (sample && !i2c_ack) ? 1'b1 : (err_clr ? 1'b0 : nack_q);
  end

`ifdef SAMPLE_AVG_EN
  logic [7:0] h0_q, h1_q, h2_q;
  logic [9:0] sum;
  assign sum       = 10'(i2c_out) + 10'(h0_q) + 10'(h1_q) + 10'(h2_q);
  assign push_data = sum[9:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      h0_q <= 8'd0;
      h1_q <= 8'd0;
      h2_q <= 8'd0;
    end else if (push) begin
      h0_q <= i2c_out;
      h1_q <= h0_q;
      h2_q <= h1_q;
    end
  end
`else
  assign push_data = i2c_out;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= 16'd0;
      en_q     <= 1'b0;
      nack_q   <= 1'b0;
      ovf_q    <= 8'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      en_q     <= en;
      nack_q   <= nack_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign i2c_en           = en_q;
  assign i2c_mode         = 1'b1;
  assign i2c_address      = DEV_ADDR;
  assign i2c_register     = REG_ADDR;
  assign i2c_start        = (state_q == S_START) || (state_q == S_XFER);
  assign i2c_stop         = (state_q == S_STOP);
  assign i2c_repeat_start = 1'b0;
  assign rd_data          = mem_q[rd_ptr_q];
  assign rd_valid         = (count_q != '0);
  assign full             = is_full;
  assign nack_err         = nack_q;
  assign ovf_cnt          = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_poll_sequencer.sv
`default_nettype none
// Testbench for i2c_poll_sequencer: directed polls, expected FIFO bytes held in a scoreboard queue.
module tb_i2c_poll_sequencer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, reset = 1'b1, en = 1'b0, err_clr = 1'b0, rd_en = 1'b0, i2c_ack = 1'b0;
  logic [7:0] i2c_out = 8'd0;
  logic       i2c_en, i2c_mode, i2c_start, i2c_stop, i2c_repeat_start;
  logic [6:0] i2c_address;
  logic [7:0] i2c_register, rd_data, ovf_cnt;
  logic       rd_valid, full, nack_err;

  int         vectors = 0, errs = 0, exp_ovf = 0;
  logic [7:0] sb[$];
`ifdef SAMPLE_AVG_EN
  logic [7:0] h0 = 8'd0, h1 = 8'd0, h2 = 8'd0;
`endif

  i2c_poll_sequencer #(
    .PERIOD(16'd20), .START_HOLD(16'd2), .XFER_CYCLES(16'd8), .STOP_HOLD(16'd2), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .err_clr(err_clr),
    .i2c_en(i2c_en), .i2c_mode(i2c_mode), .i2c_address(i2c_address), .i2c_register(i2c_register),
    .i2c_start(i2c_start), .i2c_stop(i2c_stop), .i2c_repeat_start(i2c_repeat_start),
    .i2c_out(i2c_out), .i2c_ack(i2c_ack), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .full(full), .nack_err(nack_err), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    exp_ovf = 0;
`ifdef SAMPLE_AVG_EN
    h0 = 8'd0; h1 = 8'd0; h2 = 8'd0;
`endif
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!i2c_start && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_start_seen"}, 32'(i2c_start), 32'd1);
  endtask

  // One full poll; lv = rd_valid on the sample cycle, fv = rd_valid on the first STOP cycle.
  task automatic run_poll(input string tag, input logic [7:0] d, input logic a,
                          input int drop_at, output logic lv, output logic fv);
    int n = 0, m = 0;
    logic [7:0] v;
`ifdef SAMPLE_AVG_EN
    logic [9:0] s;
`endif
    wait_start(tag);
    i2c_out = d;
    i2c_ack = a;
    lv = 1'b0;
    while (i2c_start && n < 50) begin
      if (n == drop_at) en = 1'b0;
      lv = rd_valid;
      step();
      n++;
    end
    chk({tag, "_start_len"}, n, 32'd10);
    chk({tag, "_stop_on"}, 32'(i2c_stop), 32'd1);
    fv = rd_valid;
    if (a) begin
`ifdef SAMPLE_AVG_EN
      s = 10'(d) + 10'(h0) + 10'(h1) + 10'(h2);
      v = s[9:2];
      h2 = h1; h1 = h0; h0 = d;
`else
      v = d;
`endif
      if (sb.size() < DEPTH) sb.push_back(v);
      else if (exp_ovf < 255) exp_ovf++;
    end
    while (i2c_stop && m < 50) begin
      step();
      m++;
    end
    chk({tag, "_stop_len"}, m, 32'd2);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    chk({tag, "_data"}, 32'(rd_data), 32'(e));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_i2c_en"}, 32'(i2c_en), 32'd0);
    chk({tag, "_mode"}, 32'(i2c_mode), 32'd1);
    chk({tag, "_addr"}, 32'(i2c_address), 32'h71);
    chk({tag, "_reg"}, 32'(i2c_register), 32'hFF);
    chk({tag, "_start"}, 32'(i2c_start), 32'd0);
    chk({tag, "_stop"}, 32'(i2c_stop), 32'd0);
    chk({tag, "_rpt"}, 32'(i2c_repeat_start), 32'd0);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_nack"}, 32'(nack_err), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf_cnt), 32'd0);
  endtask

  initial begin
    logic lv, fv;
    int   n;

    reset = 1'b1;
    step();
    step();
    chk_reset_vals("rst");
    reset = 1'b0;
    en    = 1'b1;

    // Single poll: timing of Start/Stop and FWFT latency
    run_poll("t1", 8'hF0, 1'b1, -1, lv, fv);
    chk("t1_valid_at_sample", 32'(lv), 32'd0);
    chk("t1_valid_after", 32'(fv), 32'd1);
    pop_check("t1_pop");
    chk("t1_empty", 32'(rd_valid), 32'd0);

    // Overflow: six polls into a 4-deep FIFO
    for (int i = 1; i <= 6; i++) begin
      run_poll("t2", 8'(i), 1'b1, -1, lv, fv);
      if (i == 3) chk("t2_not_full3", 32'(full), 32'd0);
      if (i == 4) chk("t2_full4", 32'(full), 32'd1);
    end
    chk("t2_ovf", 32'(ovf_cnt), 32'(exp_ovf));
    chk("t2_full6", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) pop_check("t2_pop");
    chk("t2_empty", 32'(rd_valid), 32'd0);

    // Nack: no push, sticky error until err_clr
    run_poll("t3", 8'h77, 1'b0, -1, lv, fv);
    chk("t3_nack", 32'(nack_err), 32'd1);
    chk("t3_no_push", 32'(rd_valid), 32'd0);
    step(); step(); step();
    chk("t3_nack_hold", 32'(nack_err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t3_nack_clr", 32'(nack_err), 32'd0);

    // en dropped mid-XFER: sequence completes, then stays idle
    run_poll("t4", 8'h55, 1'b1, 4, lv, fv);
    chk("t4_i2c_en", 32'(i2c_en), 32'd0);
    n = 0;
    repeat (60) begin
      step();
      if (i2c_start || i2c_stop) n++;
    end
    chk("t4_idle", n, 32'd0);
    chk("t4_valid", 32'(rd_valid), 32'd1);
    chk("t4_data", 32'(rd_data), 32'h55);
    chk("t4_ovf", 32'(ovf_cnt), 32'(exp_ovf));

    // Reset mid-XFER with FIFO and ovf non-zero
    en = 1'b1;
    wait_start("t5");
    repeat (5) step();
    reset = 1'b1;
    step();
    chk_reset_vals("t5");
    reset = 1'b0;
    clear_model();
    run_poll("t5b", 8'hA5, 1'b1, -1, lv, fv);
    pop_check("t5_pop");
    chk("t5_empty", 32'(rd_valid), 32'd0);

`ifdef SAMPLE_AVG_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < 4; i++) run_poll("t6", 8'd8, 1'b1, -1, lv, fv);
    for (int i = 0; i < 4; i++) pop_check("t6_pop");
`endif

    en = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
`default_nettype wire
